// File: rtl/am_dma_pkg.sv
// Shared types and geometry helpers for the DMA <-> associative-memory bridge.
package am_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_FILL,
      WR_ISSUE,
      RD_ISSUE,
      RD_CAPTURE,
      RD_DRAIN,
      DONE
   } dma_state_e;

   function automatic int calc_bpr(input int hv_length, input int beat_w);
      return hv_length / beat_w;
   endfunction

   function automatic int calc_row_bytes(input int hv_length);
      return hv_length / 8;
   endfunction

endpackage

// File: rtl/am_dma_bridge_buffer.sv
// hv_beat_buffer: one AM row of storage, filled beat-by-beat or loaded whole,
// read back one beat at a time.
module hv_beat_buffer
#(
   parameter int HV_LENGTH = 2048,
   parameter int BEAT_W    = 64,
   parameter int IDX_W     = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 beat_wen_i,
   input  logic [IDX_W-1:0]     beat_widx_i,
   input  logic [BEAT_W-1:0]    beat_wdata_i,
   input  logic                 row_load_i,
   input  logic [HV_LENGTH-1:0] row_data_i,
   input  logic [IDX_W-1:0]     beat_ridx_i,
   output logic [BEAT_W-1:0]    beat_rdata_o,
   output logic [HV_LENGTH-1:0] row_o
);

   logic [HV_LENGTH-1:0] row_d, row_q;

   always_comb begin
      row_d = row_q;
      if (row_load_i) begin
         row_d = row_data_i;
      end else if (beat_wen_i) begin
         row_d[int'(beat_widx_i)*BEAT_W +: BEAT_W] = beat_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         row_q <= '0;
      end else begin
         row_q <= row_d;
      end
   end

   assign beat_rdata_o = row_q[int'(beat_ridx_i)*BEAT_W +: BEAT_W];
   assign row_o        = row_q;

endmodule

// File: rtl/am_dma_bridge.sv
// Converts DMA beat streams to full-row AM writes and AM row reads back to
// beat streams, yielding the AM port to the encoder whenever am_busy_i is set.
//
// state      | meaning
// IDLE       | waiting for a command; rejects misaligned addresses
// WR_FILL    | collecting BPR write beats into the row buffer
// WR_ISSUE   | waiting for a free AM port, then one write strobe
// RD_ISSUE   | waiting for a free AM port, then one read strobe
// RD_CAPTURE | loading the returned row, or retrying if the encoder intervened
// RD_DRAIN   | streaming the row buffer out as beats
// DONE       | one-cycle completion pulse
module am_dma_bridge
   import am_dma_pkg::*;
#(
   parameter int HV_LENGTH      = 2048,
   parameter int BEAT_W         = 64,
   parameter int EXT_ADDR_WIDTH = 48,
   parameter int ROW_CNT_W      = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [EXT_ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [ROW_CNT_W-1:0]      cmd_rows_i,
   input  logic                      wr_beat_valid_i,
   output logic                      wr_beat_ready_o,
   input  logic [BEAT_W-1:0]         wr_beat_data_i,
   output logic                      rd_beat_valid_o,
   input  logic                      rd_beat_ready_i,
   output logic [BEAT_W-1:0]         rd_beat_data_o,
   input  logic                      am_busy_i,
   output logic [EXT_ADDR_WIDTH-1:0] ext_am_addr_o,
   output logic                      ext_am_wen_o,
   output logic                      ext_am_ren_o,
   output logic [HV_LENGTH-1:0]      ext_am_wdata_o,
   input  logic [HV_LENGTH-1:0]      ext_am_rdata_i,
   output logic                      done_o,
   output logic                      err_o
);

   localparam int BPR       = calc_bpr(HV_LENGTH, BEAT_W);
   localparam int ROW_BYTES = calc_row_bytes(HV_LENGTH);
   localparam int CNT_W     = (BPR > 1) ? $clog2(BPR) : 1;
   localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BPR - 1);
   localparam logic [EXT_ADDR_WIDTH-1:0] ROW_STEP  = EXT_ADDR_WIDTH'(ROW_BYTES);

   dma_state_e                state_d, state_q;
   logic [EXT_ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [ROW_CNT_W-1:0]      rows_d, rows_q;
   logic [CNT_W-1:0]          beat_cnt_d, beat_cnt_q;
   logic [BEAT_W-1:0]         rd_data_d, rd_data_q;
   logic                      err_d, err_q;

   logic                      buf_wen, buf_load;
   logic [CNT_W-1:0]          buf_ridx;
   logic [BEAT_W-1:0]         buf_rdata;
   logic                      misaligned;

   assign misaligned = (cmd_addr_i % ROW_STEP) != '0;
   // Prefetch the next slot so rd_beat_data_o can stay a plain register.
   assign buf_ridx   = beat_cnt_q + CNT_W'(1);

   hv_beat_buffer #(
      .HV_LENGTH (HV_LENGTH),
      .BEAT_W    (BEAT_W),
      .IDX_W     (CNT_W)
   ) u_buf (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .beat_wen_i   (buf_wen),
      .beat_widx_i  (beat_cnt_q),
      .beat_wdata_i (wr_beat_data_i),
      .row_load_i   (buf_load),
      .row_data_i   (ext_am_rdata_i),
      .beat_ridx_i  (buf_ridx),
      .beat_rdata_o (buf_rdata),
      .row_o        (ext_am_wdata_o)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rows_d          = rows_q;
      beat_cnt_d      = beat_cnt_q;
      rd_data_d       = rd_data_q;
      err_d           = 1'b0;
      buf_wen         = 1'b0;
      buf_load        = 1'b0;
      cmd_ready_o     = 1'b0;
      wr_beat_ready_o = 1'b0;
      rd_beat_valid_o = 1'b0;
      ext_am_wen_o    = 1'b0;
      ext_am_ren_o    = 1'b0;
      done_o          = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               if (misaligned) begin
                  err_d = 1'b1;
               end else if (cmd_rows_i == '0) begin
                  state_d = DONE;
               end else begin
                  addr_d     = cmd_addr_i;
                  rows_d     = cmd_rows_i;
                  beat_cnt_d = '0;
                  state_d    = cmd_write_i ? WR_FILL : RD_ISSUE;
               end
            end
         end
         WR_FILL: begin
            wr_beat_ready_o = 1'b1;
            if (wr_beat_valid_i) begin
               buf_wen = 1'b1;
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  state_d    = WR_ISSUE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         WR_ISSUE: begin
            if (!am_busy_i) begin
               ext_am_wen_o = 1'b1;
               addr_d       = addr_q + ROW_STEP;
               rows_d       = rows_q - ROW_CNT_W'(1);
               state_d      = (rows_q == ROW_CNT_W'(1)) ? DONE : WR_FILL;
            end
         end
         RD_ISSUE: begin
            if (!am_busy_i) begin
               ext_am_ren_o = 1'b1;
               state_d      = RD_CAPTURE;
            end
         end
         RD_CAPTURE: begin
            // Encoder traffic in the capture cycle may have corrupted the row.
            if (!am_busy_i) begin
               buf_load   = 1'b1;
               rd_data_d  = ext_am_rdata_i[BEAT_W-1:0];
               beat_cnt_d = '0;
               state_d    = RD_DRAIN;
            end else begin
               state_d = RD_ISSUE;
            end
         end
         RD_DRAIN: begin
            rd_beat_valid_o = 1'b1;
            if (rd_beat_ready_i) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d = '0;
                  addr_d     = addr_q + ROW_STEP;
                  rows_d     = rows_q - ROW_CNT_W'(1);
                  state_d    = (rows_q == ROW_CNT_W'(1)) ? DONE : RD_ISSUE;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
                  rd_data_d  = buf_rdata;
               end
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rows_q     <= '0;
         beat_cnt_q <= '0;
         rd_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rows_q     <= rows_d;
         beat_cnt_q <= beat_cnt_d;
         rd_data_q  <= rd_data_d;
         err_q      <= err_d;
      end
   end

   assign ext_am_addr_o  = addr_q;
   assign rd_beat_data_o = rd_data_q;
   assign err_o          = err_q;

endmodule

// File: doc/am_dma_bridge.md
# am_dma_bridge

Upstream DMA-side adapter for the accelerator's external associative-memory port. It converts narrow BEAT_W-wide DMA beat streams into full HV_LENGTH-wide single-cycle AM row writes, and AM row reads back into beat streams. It issues accesses only while the accelerator's encoder is not using the AM, because encoder traffic has priority on the shared memory port. Multi-row commands walk consecutive AM rows.

## Interface
Parameters:
- HV_LENGTH, 2048: AM row width in bits.
- BEAT_W, 64: DMA beat width; HV_LENGTH must be a multiple of BEAT_W.
- EXT_ADDR_WIDTH, 48: external AM byte-address width.
- ROW_CNT_W, 8: width of the row-count field.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_write_i  in  1  1 = DMA→AM write, 0 = AM→DMA read.
- cmd_addr_i  in  EXT_ADDR_WIDTH  start byte address; must be row-aligned.
- cmd_rows_i  in  ROW_CNT_W  number of rows to transfer.
- wr_beat_valid_i / wr_beat_ready_o  in/out  1  write-beat handshake.
- wr_beat_data_i  in  BEAT_W  write beat.
- rd_beat_valid_o / rd_beat_ready_i  out/in  1  read-beat handshake.
- rd_beat_data_o  out  BEAT_W  read beat.
- am_busy_i  in  1  encoder currently owns the AM port.
- ext_am_addr_o  out  EXT_ADDR_WIDTH  AM byte address.
- ext_am_wen_o, ext_am_ren_o  out  1  single-cycle write/read strobes.
- ext_am_wdata_o  out  HV_LENGTH  row write data.
- ext_am_rdata_i  in  HV_LENGTH  row read data, valid the cycle after ext_am_ren_o.
- done_o  out  1  one-cycle pulse when a command completes.
- err_o  out  1  one-cycle pulse when a command is rejected.

## Operation
- BPR = HV_LENGTH/BEAT_W beats per row. ROW_BYTES = HV_LENGTH/8.
- Beat k maps to row bits [k*BEAT_W +: BEAT_W]; beat 0 is the LSBs.
- IDLE: cmd_ready_o=1.
  - Misaligned address (cmd_addr_i mod ROW_BYTES ≠ 0): pulse err_o, stay in IDLE.
  - cmd_rows_i=0: go to DONE.
  - Otherwise latch addr and rows; go to WR_FILL if cmd_write_i, else RD_ISSUE.
- WR_FILL: wr_beat_ready_o=1. Each accepted beat is stored in slot beat_cnt. On the BPR-th beat go to WR_ISSUE.
- WR_ISSUE: while am_busy_i=1, wait with strobes low. Otherwise assert ext_am_wen_o for exactly one cycle, then add ROW_BYTES to addr and decrement rows. Go to DONE if rows reaches 0, else WR_FILL.
- RD_ISSUE: while am_busy_i=1, wait. Otherwise assert ext_am_ren_o for one cycle and go to RD_CAPTURE.
- RD_CAPTURE: if am_busy_i=0, load ext_am_rdata_i into the buffer and go to RD_DRAIN. If am_busy_i=1, the captured data is unreliable: discard it and return to RD_ISSUE (retry the same row).
- RD_DRAIN: rd_beat_valid_o=1 with rd_beat_data_o = slot beat_cnt. On each handshake beat_cnt increments. After the last beat, add ROW_BYTES to addr and decrement rows. Go to DONE if rows reaches 0, else RD_ISSUE.
- DONE: done_o=1 for one cycle, then IDLE.
- Address arithmetic is a full EXT_ADDR_WIDTH add and wraps modulo 2^EXT_ADDR_WIDTH. Truncation to the AM width happens downstream.
- ext_am_addr_o, ext_am_wdata_o (buffer) and rd_beat_data_o are registered.
- Strobes and ready/valid are decoded from state and am_busy_i.

## Timing
- Reset values: state IDLE; all strobes, valids, readies, done_o and err_o are 0, except cmd_ready_o=1; ext_am_addr_o=0; buffer=0, so ext_am_wdata_o=0 and rd_beat_data_o=0.
- Reset asserted mid-command aborts it immediately; no strobe or done_o is issued.
- Write row latency: BPR beat cycles (minimum) + 1 issue cycle.
- Read row latency: 1 issue + 1 capture + BPR drain cycles (minimum).
- Each am_busy_i stall adds one cycle per busy cycle. A retry from RD_CAPTURE adds two cycles or more.
- done_o rises the cycle after the final strobe (write) or final beat handshake (read).
- err_o rises the cycle after the rejected handshake.
- No command is accepted outside IDLE.
- Write beats are never accepted outside WR_FILL.
- rd_beat_valid_o, once high, stays high with stable data until the handshake.

## Structure
- Package am_dma_pkg holds:
  - state enum: IDLE, WR_FILL, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RD_DRAIN, DONE;
  - functions computing BPR and ROW_BYTES from the parameters.
- Sub-module hv_beat_buffer: HV_LENGTH register with beat-indexed write, full-row load, beat-indexed read, and async reset to 0.
- beat_cnt is log2(BPR) bits wide.

## Test plan
- Write 1 row at addr 0x100, beats i = 64'h1000+i: one wen pulse after 32 beats with addr 0x100; ext_am_wdata_o[63:0]=0x1000 and [2047:1984]=0x101F; done_o one cycle later.
- Read 2 rows from 0x0 (SRAM model preloaded): two ren pulses, at 0x0 then 0x100; 64 beats in order; done_o after the last beat; random rd_beat_ready_i backpressure gives no lost or duplicated beats.
- am_busy_i held high 5 cycles during WR_ISSUE: wen delayed exactly 5 cycles, no strobe while busy.
- am_busy_i high in RD_CAPTURE: ren reissued for the same address, and the drained data matches memory.
- cmd_addr_i=0x101: err_o pulse, no strobes. cmd_rows_i=0: done_o pulse, no strobes.
- rst_ni asserted mid-WR_FILL: outputs return to their reset values; a new write command completes correctly afterwards.
